alu_pipe_core: RTL and testbench

//  Parametrised, registered successor to the combinational 32-bit ALU datapath.
//  - Ops: AND/OR/XOR, CLA-style ADD/SUB, LUI and set-less-than, plus flags.
//  - Sits between decode/operand-fetch and writeback, with valid/ready on both sides.
//  - One result register (latency 1); optional multi-cycle shift-add multiplier.

---
 rtl/alu_pipe_core.sv | 121 ++++++++++++
 tb/tb_alu_pipe_core.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: registered ALU stage with valid/ready handshakes; define ALU_MUL_EN for the multi-cycle shift-add multiplier
module alu_pipe_core #(
  parameter int DATA_WIDTH = 32,
  parameter int LUI_SHIFT  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            flags,
  output logic                  illegal,
  output logic                  busy
);
  localparam int W = DATA_WIDTH;
  logic          sub, cin, cout, ovf, arith, bad_op, out_free, accept, is_mul, mul_load;
  logic [W-1:0]  bb, p0, g, p, sum, alu_res, mul_res;
  logic [3:0]    alu_flags;
  assign out_free = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign sub      = op == 4'd4;
  assign cin      = sub;
  assign bb       = sub ? ~b : b;
  assign p0       = a ^ bb;
  // Kogge-Stone carry lookahead shared by ADD and SUB; carry-in folded into bit 0 generate
  always_comb begin
    g = (a & bb) | {{(W-1){1'b0}}, p0[0] & cin};
    p = p0;
    for (int s = 1; s < W; s = s * 2) begin
      g = g | (p & (g << s));
      p = p & ((p << s) | ((W'(1) << s) - W'(1)));
    end
  end
  assign sum   = p0 ^ {g[W-2:0], cin};
  assign cout  = g[W-1];
  assign ovf   = (a[W-1] == bb[W-1]) & (sum[W-1] != a[W-1]);
  assign arith = (op == 4'd3) | sub;
  // Single-cycle op select; unsupported opcodes fall through to zero
  always_comb begin
    alu_res   = op == 4'd0 ? a & b :
                op == 4'd1 ? a | b :
                op == 4'd2 ? a ^ b :
                arith      ? sum :
                op == 4'd5 ? b << LUI_SHIFT :
                op == 4'd6 ? {{(W-1){1'b0}}, $signed(a) < $signed(b)} :
                op == 4'd7 ? {{(W-1){1'b0}}, a < b} : '0;
    alu_flags = {alu_res[W-1], alu_res == '0, arith & cout, arith & ovf};
  end
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int CW = $clog2(W);
  state_t        state, state_nx;
  logic [W-1:0]  acc, mcand, mplier;
  logic [CW-1:0] cnt;
  assign is_mul   = op == 4'd8;
  assign bad_op   = op > 4'd8;
  assign in_ready = (state == IDLE) & out_free;
  assign busy     = state != IDLE;
  assign mul_load = (state == DONE) & out_free;
  assign mul_res  = acc;
  // Multiplier state register; reset aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Next state: one multiplier bit per cycle, then hold in DONE until the output register frees
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept & is_mul ? MUL : IDLE) :
               state == MUL  ? (cnt == CW'(W-1) ? DONE : MUL) :
                               (out_free ? IDLE : DONE);
  end
  // Shift-add datapath: multiplicand shifts left, multiplier shifts right
  always_ff @(posedge clk) begin
    if (accept & is_mul) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign bad_op   = op > 4'd7;
  assign in_ready = out_free;
  assign busy     = 1'b0;
  assign mul_load = 1'b0;
  assign mul_res  = '0;
`endif
  // Output register: product load, new ALU result, or drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      illegal   <= 1'b0;
    end else if (mul_load) begin
      out_valid <= 1'b1;
      result    <= mul_res;
      flags     <= {mul_res[W-1], mul_res == '0, 2'b00};
      illegal   <= 1'b0;
    end else if (accept & ~is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      flags     <= alu_flags;
      illegal   <= bad_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe_core.sv
// tb_alu_pipe_core: directed and randomized checks of alu_pipe_core against a behavioural model
module tb_alu_pipe_core;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, illegal, busy;
  logic [31:0] result;
  logic [3:0]  flags;
  int          checks = 0, errors = 0;

  alu_pipe_core #(.DATA_WIDTH(32), .LUI_SHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags(flags), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic is_mul_op(input logic [3:0] o);
`ifdef ALU_MUL_EN
    return o == 4'd8;
`else
    return 1'b0;
`endif
  endfunction

  // Returns {illegal, N, Z, C, V, result} from the arithmetic definitions
  function automatic logic [36:0] alu_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx = {{32{x[31]}}, x};
    longint          sy = {{32{y[31]}}, y};
    longint unsigned ux = {32'h0, x};
    longint unsigned uy = {32'h0, y};
    longint          s = 0;
    logic [31:0]     r = '0;
    logic            c = 1'b0, v = 1'b0;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x ^ y;
      4'd3: begin r = x + y; c = (ux + uy) > 64'hFFFF_FFFF; s = sx + sy; v = s != {{32{r[31]}}, r}; end
      4'd4: begin r = x - y; c = ux >= uy; s = sx - sy; v = s != {{32{r[31]}}, r}; end
      4'd5: r = y << 12;
      4'd6: r = {31'h0, sx < sy};
      4'd7: r = {31'h0, ux < uy};
      default: return {1'b1, 4'b0100, 32'h0};
    endcase
    return {1'b0, r[31], r == 32'h0, c, v, r};
  endfunction

  logic        m_valid = 1'b0, m_ill = 1'b0;
  logic [31:0] m_res = '0, mul_p = '0;
  logic [3:0]  m_flags = '0;
  int          mul_left = 0;
  logic        exp_in_ready;
  assign exp_in_ready = (mul_left == 0) && (!m_valid || out_ready);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_res <= '0; m_flags <= '0; m_ill <= 1'b0; mul_left <= 0;
    end else begin
      if (out_ready) m_valid <= 1'b0;
      if (in_valid && exp_in_ready) begin
        if (is_mul_op(op)) begin
          mul_left <= 33;
          mul_p    <= a * b;
        end else begin
          {m_ill, m_flags, m_res} <= alu_model(op, a, b);
          m_valid <= 1'b1;
        end
      end
      if (mul_left > 1) mul_left <= mul_left - 1;
      else if (mul_left == 1 && (!m_valid || out_ready)) begin
        mul_left <= 0;
        m_valid  <= 1'b1;
        m_res    <= mul_p;
        m_flags  <= {mul_p[31], mul_p == 32'h0, 2'b00};
        m_ill    <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    chk("pin_add",  64'(alu_model(4'd3,  32'hFFFF_FFFF, 32'h1)),         {27'h0, 1'b0, 4'b0110, 32'h0});
    chk("pin_sub",  64'(alu_model(4'd4,  32'h8000_0000, 32'h1)),         {27'h0, 1'b0, 4'b0011, 32'h7FFF_FFFF});
    chk("pin_and",  64'(alu_model(4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00)), {27'h0, 1'b0, 4'b1000, 32'hF000_F000});
    chk("pin_lui",  64'(alu_model(4'd5,  32'h0,         32'h000A_BCDE)), {27'h0, 1'b0, 4'b1000, 32'hABCD_E000});
    chk("pin_slt",  64'(alu_model(4'd6,  32'hFFFF_FFFF, 32'h1)),         {27'h0, 1'b0, 4'b0000, 32'h1});
    chk("pin_sltu", 64'(alu_model(4'd7,  32'hFFFF_FFFF, 32'h1)),         {27'h0, 1'b0, 4'b0100, 32'h0});
    chk("pin_ill",  64'(alu_model(4'd15, 32'h1234_5678, 32'h9)),         {27'h0, 1'b1, 4'b0100, 32'h0});
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready",  64'(in_ready),  64'(exp_in_ready));
      chk("busy",      64'(busy),      64'(mul_left != 0));
      chk("payload",   64'({illegal, flags, result}), 64'({m_ill, m_flags, m_res}));
    end
  end

  task automatic step(input logic v, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic r);
    in_valid = v; op = o; a = x; b = y; out_ready = r;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    step(1, 4'd3, 32'h5, 32'h6, 1);
    step(1, 4'd3, 32'h5, 32'h6, 1);
    rst_n = 1'b1;
    step(0, 4'd0, 32'h0, 32'h0, 1);
    step(1, 4'd3, 32'hFFFF_FFFF, 32'h1, 1);
    step(1, 4'd4, 32'h8000_0000, 32'h1, 1);
    step(1, 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    repeat (3) step(1, 4'd1, 32'h1111_1111, 32'h2222_2222, 0);
    step(1, 4'd2, 32'hAAAA_5555, 32'h0F0F_0F0F, 1);
    step(1, 4'd3, 32'h7FFF_FFFF, 32'h1, 1);
    step(1, 4'd4, 32'h0, 32'h1, 1);
    step(1, 4'd6, 32'h8000_0000, 32'h7FFF_FFFF, 1);
    step(1, 4'd5, 32'h0, 32'h000A_BCDE, 1);
    step(1, 4'd6, 32'hFFFF_FFFF, 32'h1, 1);
    step(1, 4'd7, 32'hFFFF_FFFF, 32'h1, 1);
    step(1, 4'd15, 32'h1234_5678, 32'h9, 1);
    step(1, 4'd8, 32'd12345, 32'd10, 1);
    repeat (40) step(0, 4'd0, 32'h0, 32'h0, 1);
    step(1, 4'd8, 32'hDEAD_BEEF, 32'h1234_5679, 1);
    repeat (10) step(0, 4'd0, 32'h0, 32'h0, 1);
    rst_n = 1'b0;
    step(0, 4'd0, 32'h0, 32'h0, 1);
    rst_n = 1'b1;
    repeat (40) step(0, 4'd0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 399) != 0;
      step($urandom_range(0, 9) < 7, ($urandom_range(0, 11) == 0) ? 4'd8 : 4'($urandom_range(0, 15)),
           pick(), pick(), $urandom_range(0, 9) < 7);
    end
    rst_n = 1'b1;
    repeat (40) step(0, 4'd0, 32'h0, 32'h0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
